// File: rtl/uart_hex_formatter.sv
// uart_hex_formatter
// Turns binary words into ASCII hex text, most significant nibble first,
// optionally followed by CR LF. The byte stream is offered on a
// data/valid/ready interface that feeds the UART byte controller, so debug
// values can be printed on the TX line without software involvement.
//
// One word is handled at a time and is not buffered: in_ready is high only
// while idle. After the last byte of a frame has been accepted the block
// spends one cycle in IDLE before it can take the next word, so with ready
// held high a frame occupies NIBBLES + 2*APPEND_CRLF + 1 cycles.

module uart_hex_formatter #(
    parameter int WORD_W      = 32,
    parameter int APPEND_CRLF = 1,
    parameter int UPPERCASE   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] in_word,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [7:0]        data,
    output logic              valid,
    input  logic              ready,
    output logic              busy
);

    localparam int NIBBLES = WORD_W / 4;
    // Wide enough to hold NIBBLES-1; a single-nibble word still gets one bit.
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HEX  = 2'd1,
        CR   = 2'd2,
        LF   = 2'd3
    } state_t;

    state_t             state;
    state_t             state_n;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   idx_n;
    logic [IDX_W-1:0]   idx_dec;
    logic [WORD_W-1:0]  word_q;
    logic [WORD_W-1:0]  word_n;
    logic [WORD_W-1:0]  word_shifted;
    logic [3:0]         next_nib;
    logic [7:0]         data_n;
    logic               valid_n;
    logic               handshake;

    // Map one nibble to its ASCII hex digit, honouring the letter case choice.
    function automatic logic [7:0] to_ascii(input logic [3:0] n);
        logic [7:0] letter_base;
        letter_base = (UPPERCASE != 0) ? 8'h41 : 8'h61;
        if (n < 4'd10) begin
            return 8'h30 + {4'h0, n};
        end else begin
            return letter_base + {4'h0, n - 4'd10};
        end
    endfunction

    assign handshake = valid && ready;
    assign in_ready  = (state == IDLE);

    // The digit that follows the current one: the stored word shifted so that
    // nibble idx-1 lands in the low four bits.
    assign idx_dec      = idx - 1'b1;
    assign word_shifted = word_q >> {idx_dec, 2'b00};
    assign next_nib     = word_shifted[3:0];

    // Next-state and next-output logic; everything holds unless a transfer
    // happens, which is what freezes the stream under backpressure.
    always_comb begin
        state_n = state;
        idx_n   = idx;
        word_n  = word_q;
        data_n  = data;
        valid_n = valid;

        case (state)
            IDLE: begin
                if (in_valid) begin
                    word_n  = in_word;
                    idx_n   = IDX_W'(NIBBLES - 1);
                    data_n  = to_ascii(in_word[WORD_W-1 -: 4]);
                    valid_n = 1'b1;
                    state_n = HEX;
                end
            end

            HEX: begin
                if (handshake) begin
                    if (idx != '0) begin
                        idx_n  = idx_dec;
                        data_n = to_ascii(next_nib);
                    end else if (APPEND_CRLF != 0) begin
                        data_n  = 8'h0D;
                        state_n = CR;
                    end else begin
                        valid_n = 1'b0;
                        state_n = IDLE;
                    end
                end
            end

            CR: begin
                if (handshake) begin
                    data_n  = 8'h0A;
                    state_n = LF;
                end
            end

            LF: begin
                if (handshake) begin
                    valid_n = 1'b0;
                    state_n = IDLE;
                end
            end

            default: begin
                valid_n = 1'b0;
                state_n = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any partial frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            idx    <= '0;
            word_q <= '0;
            data   <= 8'h00;
            valid  <= 1'b0;
            busy   <= 1'b0;
        end else begin
            state  <= state_n;
            idx    <= idx_n;
            word_q <= word_n;
            data   <= data_n;
            valid  <= valid_n;
            busy   <= (state_n != IDLE);
        end
    end

endmodule

// File: tb/tb_uart_hex_formatter.sv
// Bench for uart_hex_formatter: three instances (32-bit default, 32-bit
// lowercase without CR LF, 8-bit default) run against a byte-queue model that
// expands each accepted word into the text it must produce.

module tb_uart_hex_formatter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] w  [3];
    logic        iv [3];
    logic        ir [3];
    logic [7:0]  d  [3];
    logic        v  [3];
    logic        r  [3];
    logic        b  [3];

    always #5 clk = ~clk;

    uart_hex_formatter #(.WORD_W(32), .APPEND_CRLF(1), .UPPERCASE(1)) u_def (
        .clk(clk), .rst(rst), .in_word(w[0]), .in_valid(iv[0]), .in_ready(ir[0]),
        .data(d[0]), .valid(v[0]), .ready(r[0]), .busy(b[0]));

    uart_hex_formatter #(.WORD_W(32), .APPEND_CRLF(0), .UPPERCASE(0)) u_low (
        .clk(clk), .rst(rst), .in_word(w[1]), .in_valid(iv[1]), .in_ready(ir[1]),
        .data(d[1]), .valid(v[1]), .ready(r[1]), .busy(b[1]));

    uart_hex_formatter #(.WORD_W(8), .APPEND_CRLF(1), .UPPERCASE(1)) u_w8 (
        .clk(clk), .rst(rst), .in_word(w[2][7:0]), .in_valid(iv[2]), .in_ready(ir[2]),
        .data(d[2]), .valid(v[2]), .ready(r[2]), .busy(b[2]));

    int           n_checks = 0;
    int           n_pass   = 0;
    byte unsigned exq   [3][$];
    byte unsigned rxlog [3][$];
    int           nibs  [3] = '{8, 8, 2};
    bit           crlf  [3] = '{1'b1, 1'b0, 1'b1};
    bit           upc   [3] = '{1'b1, 1'b0, 1'b1};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Expand a word into the text an instance must print for it.
    function automatic void push_frame(input int k, input logic [31:0] word);
        string digs;
        int    n;
        digs = upc[k] ? "0123456789ABCDEF" : "0123456789abcdef";
        for (int i = nibs[k] - 1; i >= 0; i--) begin
            n = int'((word >> (4 * i)) & 32'hF);
            exq[k].push_back(digs[n]);
        end
        if (crlf[k]) begin
            exq[k].push_back(8'h0D);
            exq[k].push_back(8'h0A);
        end
    endfunction

    // A frame is in progress exactly while the model still owes bytes.
    task automatic check_inst(input int k);
        bit pend;
        pend = (exq[k].size() != 0);
        chk($sformatf("u%0d valid", k), 32'(v[k]), 32'(pend));
        chk($sformatf("u%0d busy", k), 32'(b[k]), 32'(pend));
        chk($sformatf("u%0d in_ready", k), 32'(ir[k]), 32'(!pend));
        if (v[k] === 1'b1 && pend)
            chk($sformatf("u%0d data", k), 32'(d[k]), 32'(exq[k][0]));
        if (rst === 1'b1) begin
            exq[k].delete();
        end else begin
            if (v[k] === 1'b1 && r[k] === 1'b1 && pend) begin
                rxlog[k].push_back(d[k]);
                void'(exq[k].pop_front());
            end
            if (ir[k] === 1'b1 && iv[k] === 1'b1)
                push_frame(k, w[k]);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) check_inst(k);
    end

    task automatic send_word(input int k, input logic [31:0] word);
        bit got;
        got = 1'b0;
        @(posedge clk); #1;
        w[k]  = word;
        iv[k] = 1'b1;
        for (int c = 0; c < 100 && !got; c++) begin
            @(negedge clk);
            if (ir[k] === 1'b1) got = 1'b1;
        end
        chk($sformatf("u%0d accept", k), 32'(got), 32'd1);
        @(posedge clk); #1;
        iv[k] = 1'b0;
    endtask

    task automatic wait_idle(input int k);
        bit done;
        done = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk); #1;
            if (exq[k].size() == 0 && b[k] === 1'b0 && v[k] === 1'b0) done = 1'b1;
        end
        chk($sformatf("u%0d frame done", k), 32'(done), 32'd1);
    endtask

    task automatic wait_log(input int k, input int count);
        bit done;
        done = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk); #1;
            if (rxlog[k].size() == count) done = 1'b1;
        end
        chk($sformatf("u%0d byte count %0d", k, count), 32'(done), 32'd1);
    endtask

    task automatic check_log(input int k, input string name, input byte unsigned e[$]);
        chk({name, " length"}, 32'(rxlog[k].size()), 32'(e.size()));
        for (int i = 0; i < e.size() && i < rxlog[k].size(); i++)
            chk($sformatf("%s byte %0d", name, i), 32'(rxlog[k][i]), 32'(e[i]));
        rxlog[k].delete();
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        byte unsigned e[$];
        int           gap;
        bit           seen;
        bit           got;

        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            w[k] = 32'h0; iv[k] = 1'b0; r[k] = 1'b1;
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset data",     32'(d[0]),  32'h00);
        chk("reset valid",    32'(v[0]),  32'h0);
        chk("reset busy",     32'(b[0]),  32'h0);
        chk("reset in_ready", 32'(ir[0]), 32'h1);

        $display("[TB] DEADBEEF, ready high");
        send_word(0, 32'hDEADBEEF);
        wait_idle(0);
        e = '{8'h44, 8'h45, 8'h41, 8'h44, 8'h42, 8'h45, 8'h45, 8'h46, 8'h0D, 8'h0A};
        check_log(0, "deadbeef", e);

        $display("[TB] lowercase, no terminator");
        send_word(1, 32'h0123ABCF);
        wait_idle(1);
        e = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h61, 8'h62, 8'h63, 8'h66};
        check_log(1, "lowercase", e);

        $display("[TB] backpressure on third byte");
        send_word(0, 32'h12345678);
        wait_log(0, 2);
        @(posedge clk); #1;
        r[0] = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("stall data",  32'(d[0]), 32'h33);
            chk("stall valid", 32'(v[0]), 32'h1);
        end
        @(posedge clk); #1;
        r[0] = 1'b1;
        wait_idle(0);
        e = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h0D, 8'h0A};
        check_log(0, "backpressure", e);

        $display("[TB] back-to-back words");
        @(posedge clk); #1;
        w[0] = 32'h00000000; iv[0] = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 100 && !got; c++) begin
            @(negedge clk);
            if (ir[0] === 1'b1) got = 1'b1;
        end
        chk("b2b first accept", 32'(got), 32'd1);
        @(posedge clk); #1;
        w[0] = 32'hFFFFFFFF;
        got = 1'b0; seen = 1'b0; gap = 0;
        for (int c = 0; c < 100 && !got; c++) begin
            @(negedge clk);
            if (seen) gap++;
            if (ir[0] === 1'b1 && seen) got = 1'b1;
            if (v[0] === 1'b1 && r[0] === 1'b1 && d[0] === 8'h0A) begin
                seen = 1'b1; gap = 0;
            end
        end
        chk("b2b second accept", 32'(got), 32'd1);
        chk("b2b idle gap", 32'(gap), 32'd1);
        @(posedge clk); #1;
        iv[0] = 1'b0;
        wait_idle(0);
        e.delete();
        repeat (8) e.push_back(8'h30);
        e.push_back(8'h0D); e.push_back(8'h0A);
        repeat (8) e.push_back(8'h46);
        e.push_back(8'h0D); e.push_back(8'h0A);
        check_log(0, "back-to-back", e);

        $display("[TB] reset mid-frame");
        send_word(0, 32'hCAFEF00D);
        wait_log(0, 4);
        @(posedge clk); #1;
        chk("fifth digit", 32'(d[0]), 32'h46);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post-reset valid",    32'(v[0]),  32'h0);
        chk("post-reset busy",     32'(b[0]),  32'h0);
        chk("post-reset in_ready", 32'(ir[0]), 32'h1);
        e = '{8'h43, 8'h41, 8'h46, 8'h45};
        check_log(0, "partial", e);
        send_word(0, 32'h00000001);
        wait_idle(0);
        e.delete();
        repeat (7) e.push_back(8'h30);
        e.push_back(8'h31); e.push_back(8'h0D); e.push_back(8'h0A);
        check_log(0, "after reset", e);

        $display("[TB] 8-bit word");
        send_word(2, 32'h0000009A);
        wait_idle(2);
        e = '{8'h39, 8'h41, 8'h0D, 8'h0A};
        check_log(2, "w8", e);

        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++)
            chk($sformatf("u%0d nothing owed", k), 32'(exq[k].size()), 32'd0);

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_hex_formatter.md
Name: uart_hex_formatter

Overview:
- Upstream feeder for the UART byte controller.
- Accepts binary words on a valid/ready input and converts each one to ASCII hexadecimal, MSB nibble first.
- Optionally appends CR LF after each word.
- Drives the controller's byte-wide data/valid/ready input, so debug values can be printed on the UART Lite TX line without software.

Parameters:
- WORD_W, 32, input word width in bits; must be a multiple of 4 and ≥4; NIBBLES = WORD_W/4.
- APPEND_CRLF, 1, 1 = emit 8'h0D then 8'h0A after the last hex digit; 0 = no terminator.
- UPPERCASE, 1, 1 = digits A-F as 8'h41-8'h46; 0 = a-f as 8'h61-8'h66.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous active-high reset.
- in_word  in  WORD_W  word to print; sampled on in_valid && in_ready.
- in_valid  in  1  in_word is valid.
- in_ready  out  1  block can accept a word (idle).
- data  out  8  ASCII byte to the UART controller.
- valid  out  1  data is valid; held until accepted.
- ready  in  1  UART controller accepts the byte on valid && ready.
- busy  out  1  high while any byte of a word remains to be sent.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (clk, rst).
- Reset values: state = IDLE, in_ready=1 (combinational from IDLE), valid=0, data=8'h00, busy=0, nibble index=0, word register=0.
- All outputs except in_ready are registered.
- State IDLE:
  - in_ready=1.
  - On in_valid: latch in_word, set idx=NIBBLES-1, go to HEX.
  - The next cycle presents data=ascii(word[4*idx+3:4*idx]) with valid=1.
  - Latency from input handshake to first valid byte: 1 cycle.
- State HEX:
  - On valid && ready with idx>0: idx decrements and data updates to the next nibble in the same edge; valid stays 1 (one byte per cycle when ready is held high).
  - On valid && ready with idx==0: go to CR with data=8'h0D if APPEND_CRLF, else go to IDLE with valid=0.
- State CR: on handshake, go to LF with data=8'h0A.
- State LF: on handshake, go to IDLE with valid=0.
- Nibble-to-ASCII mapping:
  - 0-9 → 8'h30+n.
  - 10-15 → 8'h41+(n-10) if UPPERCASE, else 8'h61+(n-10).
- Backpressure: while valid=1 && ready=0, data, state and idx are frozen; valid is never dropped without a handshake.
- in_ready=0 in all states except IDLE. in_valid and in_word are ignored while busy; the word is not buffered. The upstream holds in_valid until in_ready.
- Back-to-back words: after the final handshake there is one IDLE cycle (valid=0, in_ready=1) before the next word can be accepted. Frame period with ready always high = NIBBLES + 2*APPEND_CRLF + 1 cycles.
- busy = 1 from the cycle after word acceptance until the cycle after the final byte handshake, i.e. busy = !IDLE.
- Reset mid-frame: the next cycle is IDLE with valid=0. Remaining bytes are discarded, no terminator is sent, and the partial output is not resumed.
- Simultaneous rst and a handshake: rst wins; the handshake has no effect.
- ready is ignored when valid=0.

Test Plan:
1. WORD_W=32, defaults, in_word=32'hDEADBEEF, ready tied high → data sequence 44 45 41 44 42 45 45 46 0D 0A on 10 consecutive valid cycles starting 1 cycle after acceptance; busy drops the following cycle, and in_ready=1 then.
2. UPPERCASE=0, APPEND_CRLF=0, in_word=32'h0123ABCF → 30 31 32 33 61 62 63 66, then valid=0, with no 0D/0A.
3. Backpressure: drop ready for 3 cycles on the 3rd byte of 32'h12345678 → data holds 8'h33 with valid=1 throughout; the sequence resumes 34 35 36 37 38 0D 0A with no loss or duplication.
4. Two words 32'h00000000 and 32'hFFFFFFFF presented back-to-back with in_valid held → the second is accepted exactly one idle cycle after the first word's 0A; the second frame is 46×8 0D 0A; in_valid during the first frame is not accepted.
5. Assert rst for 1 cycle during the 5th digit of 32'hCAFEF00D → next cycle valid=0, busy=0, in_ready=1; a new word 32'h00000001 then prints 30×7 31 0D 0A correctly.
6. WORD_W=8, in_word=8'h9A → 39 41 0D 0A.
